// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: responder state encoding, command opcodes and address framing.
package psram_pkg;

    typedef enum logic [3:0] {
        S_SPI_CMD = 4'd0,
        S_QPI_CMD = 4'd1,
        S_ADDR    = 4'd2,
        S_WDATA   = 4'd3,
        S_WAIT    = 4'd4,
        S_RDATA   = 4'd5,
        S_IGNORE  = 4'd6
    } psram_state_e;

    localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
    localparam logic [7:0] CMD_WRITE     = 8'h38;
    localparam logic [7:0] CMD_READ      = 8'hEB;
    localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

    localparam int unsigned PSRAM_ADDR_NIBBLES = 6;

endpackage

// File: rtl/psram_responder_if.sv
// PSRAM pin bundle as seen by the responder (slave) and by a driving initiator (master).
interface psram_responder_if;
    logic       i_psram_csn;
    logic [7:0] i_io;
    logic [7:0] o_io;
    logic       o_io_oe;
    logic       o_qpi_mode;
    logic       o_busy;
    logic       o_wr_stb;
    logic       o_err;
    logic [3:0] o_state;

    modport slave (
        input  i_psram_csn, i_io,
        output o_io, o_io_oe, o_qpi_mode, o_busy, o_wr_stb, o_err, o_state
    );

    modport master (
        output i_psram_csn, i_io,
        input  o_io, o_io_oe, o_qpi_mode, o_busy, o_wr_stb, o_err, o_state
    );
endinterface

// File: rtl/psram_responder_mem.sv
// Word store behind the responder: synchronous write, combinational read, no reset.
module psram_responder_mem #(
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);
    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/psram_responder.sv
// QPI PSRAM target model: decodes 35h/38h/EBh/F5h on a sampled nibble bus and serves a small word memory.
module psram_responder
    import psram_pkg::*;
#(
    parameter int unsigned MEM_AWIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    psram_responder_if.slave bus
);
    localparam int unsigned SLOT_W         = 5;
    localparam int unsigned ADDR_LAST_SLOT = 1 + PSRAM_ADDR_NIBBLES;
    localparam int unsigned RD_SLOT        = ADDR_LAST_SLOT + WAIT_CYCLES;

    psram_state_e          state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  armed_q, armed_d;
    logic [7:0]            spi_hi_q, spi_hi_d, spi_lo_q, spi_lo_d;
    logic [3:0]            cmd_hi_q, cmd_hi_d;
    logic                  is_read_q, is_read_d;
    logic [MEM_AWIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wbyte_q, wbyte_d;
    logic [7:0]            rd_lo_q, rd_lo_d;
    logic                  rd_second_q, rd_second_d;
    logic [7:0]            io_q, io_d;
    logic                  oe_q, oe_d;
    logic                  qpi_q, qpi_d;
    logic                  busy_q, busy_d;
    logic                  wr_stb_q, wr_stb_d;
    logic                  err_q, err_d;

    logic [3:0]            lane_hi, lane_lo;
    logic                  lane_bad;
    logic [7:0]            cmd_c;
    logic                  rd_load_c;
    logic                  mem_we_c;
    logic [15:0]           mem_wdata_c;
    logic [15:0]           mem_rdata;

    assign lane_hi  = bus.i_io[7:4];
    assign lane_lo  = bus.i_io[3:0];
    assign lane_bad = (lane_hi != lane_lo);
    assign cmd_c    = {cmd_hi_q, lane_lo};

    psram_responder_mem #(.AWIDTH(MEM_AWIDTH)) u_mem (
        .clk_i   (i_clk),
        .we_i    (mem_we_c),
        .addr_i  (addr_d),
        .wdata_i (mem_wdata_c),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_SPI_CMD;
            slot_q      <= '0;
            armed_q     <= 1'b0;
            spi_hi_q    <= '0;
            spi_lo_q    <= '0;
            cmd_hi_q    <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            wbyte_q     <= '0;
            rd_lo_q     <= '0;
            rd_second_q <= 1'b0;
            io_q        <= '0;
            oe_q        <= 1'b0;
            qpi_q       <= 1'b0;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            armed_q     <= armed_d;
            spi_hi_q    <= spi_hi_d;
            spi_lo_q    <= spi_lo_d;
            cmd_hi_q    <= cmd_hi_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            wbyte_q     <= wbyte_d;
            rd_lo_q     <= rd_lo_d;
            rd_second_q <= rd_second_d;
            io_q        <= io_d;
            oe_q        <= oe_d;
            qpi_q       <= qpi_d;
            busy_q      <= busy_d;
            wr_stb_q    <= wr_stb_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        armed_d     = armed_q;
        spi_hi_d    = spi_hi_q;
        spi_lo_d    = spi_lo_q;
        cmd_hi_d    = cmd_hi_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        wbyte_d     = wbyte_q;
        rd_lo_d     = rd_lo_q;
        rd_second_d = rd_second_q;
        io_d        = io_q;
        oe_d        = oe_q;
        qpi_d       = qpi_q;
        wr_stb_d    = 1'b0;
        err_d       = 1'b0;
        rd_load_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_wdata_c = {wbyte_q, bus.i_io};

        if (bus.i_psram_csn) begin
            // Deselect aborts whatever was in flight and re-arms decoding
            state_d = qpi_q ? S_QPI_CMD : S_SPI_CMD;
            slot_d  = '0;
            oe_d    = 1'b0;
            armed_d = 1'b1;
        end else if (!armed_q) begin
            // Select already low when reset released: no clean slot 0, sit this one out
            state_d = S_IGNORE;
        end else begin
            if (slot_q != '1) slot_d = slot_q + SLOT_W'(1);

            unique case (state_q)
                S_SPI_CMD: begin
                    spi_hi_d = {spi_hi_q[6:0], bus.i_io[4]};
                    spi_lo_d = {spi_lo_q[6:0], bus.i_io[0]};
                    if (slot_q == SLOT_W'(7)) begin
                        if (spi_hi_d == CMD_QPI_ENTER && spi_lo_d == CMD_QPI_ENTER) qpi_d = 1'b1;
                        else err_d = 1'b1;
                        state_d = S_IGNORE;
                    end
                end
                S_QPI_CMD: begin
                    if (lane_bad) begin
                        err_d   = 1'b1;
                        state_d = S_IGNORE;
                    end else if (slot_q == '0) begin
                        cmd_hi_d = lane_lo;
                    end else begin
                        case (cmd_c)
                            CMD_WRITE: begin
                                is_read_d = 1'b0;
                                state_d   = S_ADDR;
                            end
                            CMD_READ: begin
                                is_read_d = 1'b1;
                                state_d   = S_ADDR;
                            end
                            CMD_QPI_EXIT: begin
                                qpi_d   = 1'b0;
                                state_d = S_IGNORE;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_IGNORE;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (lane_bad) begin
                        err_d   = 1'b1;
                        state_d = S_IGNORE;
                    end else begin
                        // Only the low word-index bits survive, so high address bits alias
                        addr_d = MEM_AWIDTH'({addr_q, lane_lo});
                        if (slot_q == SLOT_W'(ADDR_LAST_SLOT)) begin
                            if (!is_read_q)            state_d   = S_WDATA;
                            else if (WAIT_CYCLES == 0) rd_load_c = 1'b1;
                            else                       state_d   = S_WAIT;
                        end
                    end
                end
                S_WDATA: begin
                    if (slot_q == SLOT_W'(ADDR_LAST_SLOT + 1)) begin
                        wbyte_d = bus.i_io;
                    end else begin
                        mem_we_c = 1'b1;
                        wr_stb_d = 1'b1;
                        state_d  = S_IGNORE;
                    end
                end
                S_WAIT: begin
                    if (slot_q == SLOT_W'(RD_SLOT)) rd_load_c = 1'b1;
                end
                S_RDATA: begin
                    if (!rd_second_q) begin
                        io_d        = rd_lo_q;
                        rd_second_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = S_IGNORE;
                    end
                end
                S_IGNORE: begin
                end
                default: state_d = S_IGNORE;
            endcase

            // First read byte goes out on the last wait slot so it is on the bus for the next edge
            if (rd_load_c) begin
                io_d        = mem_rdata[15:8];
                rd_lo_d     = mem_rdata[7:0];
                oe_d        = 1'b1;
                rd_second_d = 1'b0;
                state_d     = S_RDATA;
            end
        end

        busy_d = !bus.i_psram_csn && (state_d != S_IGNORE);
    end

    assign bus.o_io       = io_q;
    assign bus.o_io_oe    = oe_q;
    assign bus.o_qpi_mode = qpi_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_wr_stb   = wr_stb_q;
    assign bus.o_err      = err_q;
    assign bus.o_state    = state_q;

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: mode entry, QPI write/read, aliasing, aborts, errors and reset.
module tb_psram_responder;
    import psram_pkg::*;

    localparam int unsigned WAIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_cnt  = 0;
    int   wr_cnt   = 0;

    psram_responder_if bus ();

    psram_responder #(.MEM_AWIDTH(8), .WAIT_CYCLES(WAIT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Each registered pulse is visible at exactly one rising edge
    always @(posedge clk) begin
        if (bus.o_err)    err_cnt++;
        if (bus.o_wr_stb) wr_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic slot(input logic [7:0] v);
        @(negedge clk);
        bus.i_psram_csn = 1'b0;
        bus.i_io        = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_psram_csn = 1'b1;
            bus.i_io        = 8'h00;
        end
    endtask

    task automatic spi_byte(input logic [7:0] hi, input logic [7:0] lo);
        for (int i = 7; i >= 0; i--) slot({3'b000, hi[i], 3'b000, lo[i]});
    endtask

    task automatic qpi_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [3:0] nib;
        slot({cmd[7:4], cmd[7:4]});
        slot({cmd[3:0], cmd[3:0]});
        for (int i = 5; i >= 0; i--) begin
            nib = addr[i*4 +: 4];
            slot({nib, nib});
        end
    endtask

    task automatic qpi_write(input logic [23:0] addr, input logic [15:0] data);
        qpi_hdr(CMD_WRITE, addr);
        slot(data[15:8]);
        check_eq("wr_busy", 32'(bus.o_busy), 32'd1);
        slot(data[7:0]);
        @(negedge clk);
        check_eq("wr_stb", 32'(bus.o_wr_stb), 32'd1);
        bus.i_psram_csn = 1'b1;
        bus.i_io        = 8'h00;
    endtask

    task automatic qpi_read(input string tag, input logic [23:0] addr, input logic [15:0] exp);
        logic [7:0] hi_b, lo_b;
        qpi_hdr(CMD_READ, addr);
        repeat (WAIT) slot(8'h00);
        @(negedge clk);
        hi_b = bus.o_io;
        check_eq({tag, "_oe_hi"}, 32'(bus.o_io_oe), 32'd1);
        @(negedge clk);
        lo_b = bus.o_io;
        check_eq({tag, "_oe_lo"}, 32'(bus.o_io_oe), 32'd1);
        @(negedge clk);
        check_eq({tag, "_oe_off"}, 32'(bus.o_io_oe), 32'd0);
        check_eq({tag, "_data"}, 32'({hi_b, lo_b}), 32'(exp));
        bus.i_psram_csn = 1'b1;
    endtask

    initial begin
        bus.i_psram_csn = 1'b1;
        bus.i_io        = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(bus.o_state), 32'd0);
        check_eq("rst_qpi",   32'(bus.o_qpi_mode), 32'd0);
        check_eq("rst_outs",  32'({bus.o_io, bus.o_io_oe, bus.o_busy, bus.o_wr_stb, bus.o_err}), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Lane hi 0x34 against lane lo 0x35
        spi_byte(8'h34, 8'h35);
        idle(2);
        check_eq("spi_bad_err", 32'(err_cnt), 32'd1);
        check_eq("spi_bad_qpi", 32'(bus.o_qpi_mode), 32'd0);
        check_eq("spi_bad_state", 32'(bus.o_state), 32'd0);

        spi_byte(8'h35, 8'h35);
        idle(1);
        check_eq("spi_ok_qpi", 32'(bus.o_qpi_mode), 32'd1);
        idle(1);
        check_eq("spi_ok_err", 32'(err_cnt), 32'd1);
        check_eq("spi_ok_state", 32'(bus.o_state), 32'd1);
        check_eq("spi_ok_busy", 32'(bus.o_busy), 32'd0);

        qpi_write(24'h000012, 16'hA5C3);
        idle(1);
        check_eq("wr1_cnt", 32'(wr_cnt), 32'd1);
        qpi_read("rd1", 24'h000012, 16'hA5C3);

        qpi_write(24'h000112, 16'h1234);
        qpi_read("alias", 24'h000012, 16'h1234);
        check_eq("wr2_cnt", 32'(wr_cnt), 32'd2);

        // Deselect after slot 8 must not commit the word
        qpi_hdr(CMD_WRITE, 24'h000012);
        slot(8'hFF);
        idle(2);
        check_eq("abort_wr_cnt", 32'(wr_cnt), 32'd2);
        qpi_read("abort", 24'h000012, 16'h1234);

        qpi_write(24'hFFFFFF, 16'hBEEF);
        qpi_read("wrap", 24'h0000FF, 16'hBEEF);

        slot(8'h32);
        @(negedge clk);
        check_eq("lane_state", 32'(bus.o_state), 32'(S_IGNORE));
        check_eq("lane_busy", 32'(bus.o_busy), 32'd0);
        slot(8'h88);
        slot(8'h00);
        idle(2);
        check_eq("lane_err", 32'(err_cnt), 32'd2);

        qpi_hdr(8'h99, 24'h000000);
        idle(2);
        check_eq("unk_err", 32'(err_cnt), 32'd3);
        check_eq("unk_wr", 32'(wr_cnt), 32'd3);
        check_eq("unk_qpi", 32'(bus.o_qpi_mode), 32'd1);

        slot(8'hFF);
        slot(8'h55);
        @(negedge clk);
        check_eq("exit_qpi", 32'(bus.o_qpi_mode), 32'd0);
        idle(2);
        // QPI-framed EBh seen through SPI decoding: lane-0 bits read 0x42
        qpi_hdr(CMD_READ, 24'h000012);
        idle(2);
        check_eq("exit_spi_err", 32'(err_cnt), 32'd4);
        check_eq("exit_oe", 32'(bus.o_io_oe), 32'd0);

        spi_byte(8'h35, 8'h35);
        idle(2);
        check_eq("reent_qpi", 32'(bus.o_qpi_mode), 32'd1);
        qpi_hdr(CMD_WRITE, 24'h000012);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_qpi", 32'(bus.o_qpi_mode), 32'd0);
        check_eq("midrst_state", 32'(bus.o_state), 32'd0);
        check_eq("midrst_busy", 32'(bus.o_busy), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        qpi_hdr(CMD_READ, 24'h000012);
        idle(2);
        check_eq("post_rst_err", 32'(err_cnt), 32'd5);
        check_eq("post_rst_qpi", 32'(bus.o_qpi_mode), 32'd0);
        check_eq("post_rst_wr", 32'(wr_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
